menu_ctrl: RTL and testbench

Menu controller FSM that produces the `menu_state` code consumed by the menu text overlay. It also produces the cursor and car-selection values.
- Inputs: key-level signals from the keyboard decoder, the VGA `vsync` for frame timing, and `race_finished` from game logic.
- Placement: between the keyboard decoder and the menu text/overlay pipeline.
- Outputs update only at frame boundaries, so text never changes mid-frame.

---
 rtl/menu_pkg.sv | 51 +++++
 rtl/key_edge.sv | 47 ++++
 rtl/menu_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_menu_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// ============================================================================
// Module : menu_pkg
// Desc   : Shared state codes, menu item indices and key-event helpers for the
//          menu controller and the menu character ROM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package menu_pkg;

    localparam logic [2:0] MAIN      = 3'd0;
    localparam logic [2:0] CAR_SEL   = 3'd1;
    localparam logic [2:0] HELP      = 3'd2;
    localparam logic [2:0] COUNTDOWN = 3'd3;
    localparam logic [2:0] RACE      = 3'd4;
    localparam logic [2:0] RESULT    = 3'd5;

    localparam logic [1:0] ITEM_START = 2'd0;
    localparam logic [1:0] ITEM_CAR   = 2'd1;
    localparam logic [1:0] ITEM_HELP  = 2'd2;

    typedef enum logic [2:0] {
        ST_MAIN      = MAIN,
        ST_CAR_SEL   = CAR_SEL,
        ST_HELP      = HELP,
        ST_COUNTDOWN = COUNTDOWN,
        ST_RACE      = RACE,
        ST_RESULT    = RESULT
    } menu_state_e;

    typedef enum logic [2:0] {
        KEV_NONE  = 3'd0,
        KEV_ESC   = 3'd1,
        KEV_ENTER = 3'd2,
        KEV_UP    = 3'd3,
        KEV_DOWN  = 3'd4
    } key_ev_e;

    // Only the highest-priority press survives; the rest are dropped.
    function automatic key_ev_e pick_key(input logic esc, input logic enter,
                                         input logic up, input logic down);
        if (esc)        return KEV_ESC;
        else if (enter) return KEV_ENTER;
        else if (up)    return KEV_UP;
        else if (down)  return KEV_DOWN;
        else            return KEV_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_edge.sv
// ============================================================================
// Module : key_edge
// Desc   : 2-flop synchronizer plus registered rising-edge detect (one pulse
//          per press). A level already high when reset releases is ignored.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_pulse
);

    logic       r_s1;
    logic       r_s2;
    logic       r_prev;
    logic [1:0] r_vld;
    logic       r_armed;
    logic       r_pulse;

    // r_vld[1] marks r_s2 as holding a real sample rather than its reset value;
    // the detector arms only after a genuine low level has been seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_prev  <= 1'b0;
            r_vld   <= 2'b00;
            r_armed <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_s1    <= i_din;
            r_s2    <= r_s1;
            r_prev  <= r_s2;
            r_vld   <= {r_vld[0], 1'b1};
            r_armed <= r_armed | (r_vld[1] & ~r_s2);
            r_pulse <= r_s2 & ~r_prev & r_armed;
        end
    end

    assign o_pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/menu_ctrl.sv
// ============================================================================
// Module : menu_ctrl
// Desc   : Menu FSM producing frame-aligned state/cursor/countdown codes for
//          the text overlay, plus committed car selection and race start.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module menu_ctrl
    import menu_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 60,
    parameter int COUNT_START    = 3,
    parameter int RESULT_FRAMES  = 600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_enter,
    input  logic       key_esc,
    input  logic       vsync_in,
    input  logic       race_finished,
    output logic [2:0] menu_state,
    output logic [1:0] cursor,
    output logic [1:0] car_sel,
    output logic [1:0] count_val,
    output logic       race_go
);

    localparam int FC_MAX = (FRAMES_PER_SEC > RESULT_FRAMES) ? FRAMES_PER_SEC : RESULT_FRAMES;
    localparam int FCW    = $clog2(FC_MAX + 1);

    localparam logic [FCW-1:0] c_FPS_LAST = FCW'(FRAMES_PER_SEC - 1);
    localparam logic [FCW-1:0] c_RES_LAST = FCW'(RESULT_FRAMES - 1);
    localparam logic [1:0]     c_CNT_INIT = 2'(COUNT_START);

    logic [4:0] w_raw;
    logic [4:0] w_pulse;
    logic       w_tick;
    key_ev_e    w_ev;

    assign w_raw = {vsync_in, key_esc, key_enter, key_up, key_down};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_key_edge
            key_edge u_key_edge (
                .clk     (clk),
                .rst     (rst),
                .i_din   (w_raw[gi]),
                .o_pulse (w_pulse[gi])
            );
        end
    endgenerate

    assign w_tick = w_pulse[4];
    assign w_ev   = pick_key(w_pulse[3], w_pulse[2], w_pulse[1], w_pulse[0]);

    menu_state_e    r_state, w_state_nx;
    logic [1:0]     r_cur, w_cur_nx;
    logic [1:0]     r_tmp, w_tmp_nx;
    logic [1:0]     r_cnt, w_cnt_nx;
    logic [1:0]     r_car, w_car_nx;
    logic [FCW-1:0] r_fcnt, w_fcnt_nx;
    logic           r_go, w_go_nx;
    logic [2:0]     r_menu_state;
    logic [1:0]     r_cursor;
    logic [1:0]     r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_MAIN;
            r_cur        <= 2'd0;
            r_tmp        <= 2'd0;
            r_cnt        <= 2'd0;
            r_car        <= 2'd0;
            r_fcnt       <= '0;
            r_go         <= 1'b0;
            r_menu_state <= 3'd0;
            r_cursor     <= 2'd0;
            r_count      <= 2'd0;
        end else begin
            r_state <= w_state_nx;
            r_cur   <= w_cur_nx;
            r_tmp   <= w_tmp_nx;
            r_cnt   <= w_cnt_nx;
            r_car   <= w_car_nx;
            r_fcnt  <= w_fcnt_nx;
            r_go    <= w_go_nx;
            // Shadow registers publish only what is present at the frame tick.
            if (w_tick) begin
                r_menu_state <= r_state;
                r_cursor     <= r_cur;
                r_count      <= r_cnt;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cur_nx   = r_cur;
        w_tmp_nx   = r_tmp;
        w_cnt_nx   = r_cnt;
        w_car_nx   = r_car;
        w_fcnt_nx  = r_fcnt;
        w_go_nx    = 1'b0;

        case (r_state)
            ST_MAIN: begin
                case (w_ev)
                    KEV_UP:   w_cur_nx = (r_cur == ITEM_START) ? ITEM_HELP : r_cur - 2'd1;
                    KEV_DOWN: w_cur_nx = (r_cur == ITEM_HELP) ? ITEM_START : r_cur + 2'd1;
                    KEV_ENTER: begin
                        if (r_cur == ITEM_START) begin
                            w_state_nx = ST_COUNTDOWN;
                            w_cnt_nx   = c_CNT_INIT;
                            w_fcnt_nx  = '0;
                        end else if (r_cur == ITEM_CAR) begin
                            w_state_nx = ST_CAR_SEL;
                            w_tmp_nx   = r_car;
                        end else begin
                            w_state_nx = ST_HELP;
                        end
                    end
                    default: ;
                endcase
            end
            ST_CAR_SEL: begin
                case (w_ev)
                    KEV_UP:   w_tmp_nx = r_tmp + 2'd1;
                    KEV_DOWN: w_tmp_nx = r_tmp - 2'd1;
                    KEV_ENTER: begin
                        w_car_nx   = r_tmp;
                        w_state_nx = ST_MAIN;
                    end
                    KEV_ESC:  w_state_nx = ST_MAIN;
                    default: ;
                endcase
            end
            ST_HELP: begin
                if (w_ev == KEV_ENTER || w_ev == KEV_ESC)
                    w_state_nx = ST_MAIN;
            end
            ST_COUNTDOWN: begin
                if (w_ev == KEV_ESC) begin
                    w_state_nx = ST_MAIN;
                    w_fcnt_nx  = '0;
                end else if (w_tick) begin
                    if (r_fcnt == c_FPS_LAST) begin
                        w_fcnt_nx = '0;
                        w_cnt_nx  = r_cnt - 2'd1;
                        if (r_cnt == 2'd1) begin
                            w_state_nx = ST_RACE;
                            w_go_nx    = 1'b1;
                        end
                    end else begin
                        w_fcnt_nx = r_fcnt + 1'b1;
                    end
                end
            end
            ST_RACE: begin
                if (w_ev == KEV_ESC) begin
                    w_state_nx = ST_MAIN;
                end else if (race_finished) begin
                    w_state_nx = ST_RESULT;
                    w_fcnt_nx  = '0;
                end
            end
            ST_RESULT: begin
                if (w_ev == KEV_ENTER) begin
                    w_state_nx = ST_MAIN;
                end else if (w_tick) begin
                    if (r_fcnt == c_RES_LAST) begin
                        w_state_nx = ST_MAIN;
                        w_fcnt_nx  = '0;
                    end else begin
                        w_fcnt_nx = r_fcnt + 1'b1;
                    end
                end
            end
            default: w_state_nx = ST_MAIN;
        endcase
    end

    assign menu_state = r_menu_state;
    assign cursor     = r_cursor;
    assign count_val  = r_count;
    assign car_sel    = r_car;
    assign race_go    = r_go;

endmodule

`default_nettype wire

// File: tb/tb_menu_ctrl.sv
// ============================================================================
// Module : tb_menu_ctrl
// Desc   : Self-checking bench for menu_ctrl against a transaction-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_menu_ctrl;

    localparam int FPS = 2;
    localparam int CS  = 3;
    localparam int RF  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_up, key_down, key_enter, key_esc;
    logic       vsync_in, race_finished;
    logic [2:0] menu_state;
    logic [1:0] cursor, car_sel, count_val;
    logic       race_go;

    menu_ctrl #(
        .FRAMES_PER_SEC (FPS),
        .COUNT_START    (CS),
        .RESULT_FRAMES  (RF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_up        (key_up),
        .key_down      (key_down),
        .key_enter     (key_enter),
        .key_esc       (key_esc),
        .vsync_in      (vsync_in),
        .race_finished (race_finished),
        .menu_state    (menu_state),
        .cursor        (cursor),
        .car_sel       (car_sel),
        .count_val     (count_val),
        .race_go       (race_go)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int go_cnt  = 0;

    always @(negedge clk) if (race_go === 1'b1) go_cnt++;

    // Model: 0 MAIN, 1 CAR_SEL, 2 HELP, 3 COUNTDOWN, 4 RACE, 5 RESULT
    int m_state, m_cur, m_tmp, m_car, m_cnt, m_fc, m_go;
    int p_state, p_cur, p_cnt;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cur = 0; m_tmp = 0; m_car = 0; m_cnt = 0; m_fc = 0; m_go = 0;
        p_state = 0; p_cur = 0; p_cnt = 0;
    endtask

    // mask = {esc, enter, up, down}
    task automatic model_key(input logic [3:0] mask, input bit rf);
        int ev;
        ev = mask[3] ? 1 : mask[2] ? 2 : mask[1] ? 3 : mask[0] ? 4 : 0;
        case (m_state)
            0: begin
                if (ev == 3) m_cur = (m_cur + 2) % 3;
                else if (ev == 4) m_cur = (m_cur + 1) % 3;
                else if (ev == 2) begin
                    if (m_cur == 0) begin m_state = 3; m_cnt = CS; m_fc = 0; end
                    else if (m_cur == 1) begin m_state = 1; m_tmp = m_car; end
                    else m_state = 2;
                end
            end
            1: begin
                if (ev == 3) m_tmp = (m_tmp + 1) % 4;
                else if (ev == 4) m_tmp = (m_tmp + 3) % 4;
                else if (ev == 2) begin m_car = m_tmp; m_state = 0; end
                else if (ev == 1) m_state = 0;
            end
            2: if (ev == 1 || ev == 2) m_state = 0;
            3: if (ev == 1) begin m_state = 0; m_fc = 0; end
            4: begin
                if (ev == 1) m_state = 0;
                else if (rf) begin m_state = 5; m_fc = 0; end
            end
            5: if (ev == 2) m_state = 0;
            default: m_state = 0;
        endcase
    endtask

    task automatic model_tick();
        p_state = m_state; p_cur = m_cur; p_cnt = m_cnt;
        if (m_state == 3) begin
            m_fc++;
            if (m_fc == FPS) begin
                m_fc = 0;
                m_cnt--;
                if (m_cnt == 0) begin m_state = 4; m_go++; end
            end
        end else if (m_state == 5) begin
            m_fc++;
            if (m_fc == RF) begin m_state = 0; m_fc = 0; end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},  int'(menu_state), p_state);
        chk({tag, ".cursor"}, int'(cursor),     p_cur);
        chk({tag, ".count"},  int'(count_val),  p_cnt);
        chk({tag, ".car"},    int'(car_sel),    m_car);
        chk({tag, ".go"},     go_cnt,           m_go);
    endtask

    // Keys land at the FSM 3 clk after the first sampling edge; race_finished
    // is timed to coincide with that cycle when requested.
    task automatic press(input logic [3:0] mask, input int hold, input bit rf);
        @(negedge clk);
        {key_esc, key_enter, key_up, key_down} = mask;
        repeat (3) @(negedge clk);
        race_finished = rf;
        @(negedge clk);
        race_finished = 1'b0;
        repeat (hold - 4) @(negedge clk);
        {key_esc, key_enter, key_up, key_down} = 4'b0000;
        repeat (5) @(negedge clk);
        model_key(mask, rf);
    endtask

    task automatic pulse_rf();
        @(negedge clk) race_finished = 1'b1;
        @(negedge clk) race_finished = 1'b0;
        repeat (2) @(negedge clk);
        if (m_state == 4) begin m_state = 5; m_fc = 0; end
    endtask

    task automatic tick(input string tag);
        @(negedge clk) vsync_in = 1'b1;
        repeat (2) @(negedge clk);
        vsync_in = 1'b0;
        repeat (4) @(negedge clk);
        model_tick();
        check_all(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] mask;
        int         old_car;
        rst = 1'b1;
        {key_esc, key_enter, key_up, key_down} = 4'b0000;
        vsync_in = 1'b0;
        race_finished = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_all("reset");

        // Held key gives a single move.
        press(4'b0001, 100, 1'b0);
        tick("hold_down");

        // Car selection: commit, with exact 3-clk key latency on car_sel.
        press(4'b0100, 5, 1'b0);
        press(4'b0001, 5, 1'b0);
        press(4'b0001, 5, 1'b0);
        old_car = m_car;
        @(negedge clk) key_enter = 1'b1;
        repeat (3) @(negedge clk);
        chk("lat_pre", int'(car_sel), old_car);
        @(negedge clk);
        chk("lat_post", int'(car_sel), 2);
        repeat (3) @(negedge clk);
        key_enter = 1'b0;
        repeat (5) @(negedge clk);
        model_key(4'b0100, 1'b0);
        tick("commit");

        // Car selection abandoned with esc.
        press(4'b0100, 5, 1'b0);
        press(4'b0001, 5, 1'b0);
        press(4'b0001, 5, 1'b0);
        press(4'b1000, 5, 1'b0);
        tick("abort_sel");

        // Countdown to race, then esc + race_finished together.
        press(4'b0010, 5, 1'b0);
        press(4'b0100, 5, 1'b0);
        for (int i = 1; i <= 7; i++) tick($sformatf("cd%0d", i));
        press(4'b1000, 5, 1'b1);
        tick("esc_beats_fin");

        // Race -> result -> auto return.
        press(4'b0100, 5, 1'b0);
        for (int i = 0; i < 6; i++) tick("cd_b");
        pulse_rf();
        for (int i = 0; i < RF + 1; i++) tick($sformatf("res%0d", i));

        // Esc during countdown at digit 2.
        press(4'b0100, 5, 1'b0);
        for (int i = 0; i < 3; i++) tick("cd_c");
        chk("cd_c.digit", int'(count_val), 2);
        press(4'b1000, 5, 1'b0);
        tick("cd_esc");

        // Asynchronous reset mid-countdown, enter held across release.
        press(4'b0100, 5, 1'b0);
        tick("pre_rst");
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst.state", int'(menu_state), 0);
        chk("arst.car",   int'(car_sel), 0);
        chk("arst.count", int'(count_val), 0);
        chk("arst.go",    int'(race_go), 0);
        model_reset();
        go_cnt = 0;
        key_enter = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        tick("held_enter");
        key_enter = 1'b0;
        repeat (5) @(negedge clk);
        press(4'b0100, 5, 1'b0);
        tick("repress");

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: begin
                    mask = 4'($urandom_range(1, 15));
                    if ($urandom_range(0, 1) == 0)
                        mask = 4'b0001 << $urandom_range(0, 3);
                    press(mask, 4 + int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
                end
                6, 7, 8: tick($sformatf("rnd%0d", i));
                default: pulse_rf();
            endcase
        end
        tick("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
